// File: rtl/spi_seq_pkg.sv
// Shared types and SPI master core register map for the SPI transaction sequencer.
package spi_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_ST,
    S_SET_SS,
    S_SET_SSO,
    S_WAIT_TRDY,
    S_GET_TX,
    S_WR_TX,
    S_WAIT_RRDY,
    S_RD_RX,
    S_REL_SSO,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_ACC1,
    P_ACC2,
    P_GAP
  } phase_e;

  localparam logic [2:0]  SPI_ADDR_RXDATA  = 3'd0;
  localparam logic [2:0]  SPI_ADDR_TXDATA  = 3'd1;
  localparam logic [2:0]  SPI_ADDR_STATUS  = 3'd2;
  localparam logic [2:0]  SPI_ADDR_CONTROL = 3'd3;
  localparam logic [2:0]  SPI_ADDR_SSEL    = 3'd5;
  localparam logic [15:0] CTRL_SSO         = 16'h0400;

endpackage

// File: rtl/spi_seq_bus_access.sv
// One SPI core register access: two strobe cycles then one quiet cycle, during which ack is high.
module spi_seq_bus_access
  import spi_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rd,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        spi_select,
  output logic        read_n,
  output logic        write_n,
  output logic [2:0]  mem_addr,
  output logic [15:0] data_from_cpu,
  input  logic [15:0] data_to_cpu
);

  phase_e phase;

  // A new access may launch from the quiet cycle, so back-to-back accesses cost 3 cycles each.
  assign ack = (phase == P_GAP);

  // NOTE: non-blocking assignments make every register here update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase         <= P_IDLE;
      spi_select    <= 1'b0;
      read_n        <= 1'b1;
      write_n       <= 1'b1;
      mem_addr      <= 3'd0;
      data_from_cpu <= 16'h0000;
      rdata         <= 8'h00;
    end else begin
      case (phase)
        P_ACC1: phase <= P_ACC2;
        P_ACC2: begin
          phase      <= P_GAP;
          spi_select <= 1'b0;
          read_n     <= 1'b1;
          write_n    <= 1'b1;
          rdata      <= data_to_cpu[7:0];
        end
        default: begin
          if (start) begin
            phase      <= P_ACC1;
            spi_select <= 1'b1;
            read_n     <= ~rd;
            write_n    <= rd;
            mem_addr   <= addr;
            if (!rd) data_from_cpu <= wdata;
          end else begin
            phase <= P_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Drives the SPI master core register port through one command transaction.
// Optional wait-state watchdog: define SPI_SEQ_TIMEOUT_EN.
module spi_txn_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          MAX_LEN        = 16,
  parameter logic [15:0] SS_MASK        = 16'h0001,
  parameter int          TIMEOUT_CYCLES = 8192
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_byte,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic                         cmd_rd,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic [7:0]                   tx_data,
  output logic                         rx_valid,
  output logic [7:0]                   rx_data,
  output logic [7:0]                   stat_byte,
  output logic                         done,
  output logic                         err,
  output logic                         spi_select,
  output logic                         read_n,
  output logic                         write_n,
  output logic [2:0]                   mem_addr,
  output logic [15:0]                  data_from_cpu,
  input  logic [15:0]                  data_to_cpu,
  input  logic                         readyfordata,
  input  logic                         dataavailable
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_e        state;
  logic [7:0]    cmd_byte_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx;
  logic          rd_q;
  logic          timeout;

  logic          bus_start;
  logic          bus_rd;
  logic [2:0]    bus_addr;
  logic [15:0]   bus_wdata;
  logic          bus_ack;
  logic [7:0]    bus_rdata;

  // Each access is requested in the cycle the FSM decides to move, so strobes rise on that same edge.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    bus_start = 1'b0;
    bus_rd    = 1'b0;
    bus_addr  = SPI_ADDR_RXDATA;
    bus_wdata = 16'h0000;
    case (state)
      S_IDLE:      if (cmd_valid && cmd_ready) begin
                     bus_start = 1'b1;
                     bus_addr  = SPI_ADDR_STATUS;
                   end
      S_CLR_ST:    if (bus_ack) begin
                     bus_start = 1'b1;
                     bus_addr  = SPI_ADDR_SSEL;
                     bus_wdata = SS_MASK;
                   end
      S_SET_SS:    if (bus_ack) begin
                     bus_start = 1'b1;
                     bus_addr  = SPI_ADDR_CONTROL;
                     bus_wdata = CTRL_SSO;
                   end
      S_WAIT_TRDY: if (readyfordata && (idx == '0 || rd_q)) begin
                     bus_start = 1'b1;
                     bus_addr  = SPI_ADDR_TXDATA;
                     bus_wdata = (idx == '0) ? {8'h00, cmd_byte_q} : 16'h0000;
                   end
      S_GET_TX:    if (tx_valid) begin
                     bus_start = 1'b1;
                     bus_addr  = SPI_ADDR_TXDATA;
                     bus_wdata = {8'h00, tx_data};
                   end
      S_WAIT_RRDY: if (dataavailable) begin
                     bus_start = 1'b1;
                     bus_rd    = 1'b1;
                   end
      S_RD_RX:     if (bus_ack && idx == len_q) begin
                     bus_start = 1'b1;
                     bus_addr  = SPI_ADDR_CONTROL;
                   end
      default: ;
    endcase
    if (timeout) begin
      bus_start = 1'b1;
      bus_rd    = 1'b0;
      bus_addr  = SPI_ADDR_CONTROL;
      bus_wdata = 16'h0000;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      tx_ready   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      stat_byte  <= 8'h00;
      done       <= 1'b0;
      cmd_byte_q <= 8'h00;
      len_q      <= '0;
      rd_q       <= 1'b0;
      idx        <= '0;
    end else begin
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (timeout) begin
        state <= S_REL_SSO;
      end else begin
        case (state)
          S_IDLE: if (cmd_valid && cmd_ready) begin
            cmd_byte_q <= cmd_byte;
            len_q      <= cmd_len;
            rd_q       <= cmd_rd;
            idx        <= '0;
            cmd_ready  <= 1'b0;
            state      <= S_CLR_ST;
          end
          S_CLR_ST:    if (bus_ack) state <= S_SET_SS;
          S_SET_SS:    if (bus_ack) state <= S_SET_SSO;
          S_SET_SSO:   if (bus_ack) state <= S_WAIT_TRDY;
          S_WAIT_TRDY: if (readyfordata) state <= (idx == '0 || rd_q) ? S_WR_TX : S_GET_TX;
          S_GET_TX: if (tx_valid) begin
            tx_ready <= 1'b1;
            state    <= S_WR_TX;
          end
          S_WR_TX:     if (bus_ack) state <= S_WAIT_RRDY;
          S_WAIT_RRDY: if (dataavailable) state <= S_RD_RX;
          S_RD_RX: if (bus_ack) begin
            if (idx == '0) begin
              stat_byte <= bus_rdata;
            end else if (rd_q) begin
              rx_valid <= 1'b1;
              rx_data  <= bus_rdata;
            end
            if (idx == len_q) begin
              state <= S_REL_SSO;
            end else begin
              idx   <= idx + LW'(1);
              state <= S_WAIT_TRDY;
            end
          end
          S_REL_SSO: if (bus_ack) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
          S_DONE: begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [13:0] WD_LAST = 14'(TIMEOUT_CYCLES - 1);

  logic [13:0] wd_cnt;
  logic        stalled;

  always_comb begin
    stalled = ((state == S_WAIT_TRDY) && !readyfordata) ||
              ((state == S_GET_TX)    && !tx_valid)     ||
              ((state == S_WAIT_RRDY) && !dataavailable);
  end

  assign timeout = stalled && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= 14'd0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= (stalled && !timeout) ? wd_cnt + 14'd1 : 14'd0;
      if (state == S_IDLE && cmd_valid && cmd_ready) err <= 1'b0;
      else if (timeout)                             err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  spi_seq_bus_access u_bus (
    .clk           (clk),
    .reset         (reset),
    .start         (bus_start),
    .rd            (bus_rd),
    .addr          (bus_addr),
    .wdata         (bus_wdata),
    .ack           (bus_ack),
    .rdata         (bus_rdata),
    .spi_select    (spi_select),
    .read_n        (read_n),
    .write_n       (write_n),
    .mem_addr      (mem_addr),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu)
  );

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer: bus-access log, rx/done monitors and a minimal SPI core model.
module tb_spi_txn_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_byte = 8'h00;
  logic [4:0]  cmd_len = 5'd0;
  logic        cmd_rd = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data = 8'h00;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  stat_byte;
  logic        done;
  logic        err;
  logic        spi_select;
  logic        read_n;
  logic        write_n;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu = 16'h0000;
  logic        readyfordata = 1'b1;
  logic        dataavailable = 1'b1;

  spi_txn_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_byte      (cmd_byte),
    .cmd_len       (cmd_len),
    .cmd_rd        (cmd_rd),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .stat_byte     (stat_byte),
    .done          (done),
    .err           (err),
    .spi_select    (spi_select),
    .read_n        (read_n),
    .write_n       (write_n),
    .mem_addr      (mem_addr),
    .data_from_cpu (data_from_cpu),
    .data_to_cpu   (data_to_cpu),
    .readyfordata  (readyfordata),
    .dataavailable (dataavailable)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Core model: the low byte returned on the Nth read is rx_vals[N]; the high byte is junk.
  logic [7:0] rx_vals [256];
  int         rd_cnt = 0;
  logic       model_prev = 1'b0;

  always @(posedge clk) begin
    model_prev <= spi_select;
    if (spi_select && !model_prev && !read_n) begin
      data_to_cpu <= {8'hEE, rx_vals[rd_cnt]};
      rd_cnt      <= rd_cnt + 1;
    end
  end

  // Monitor: one log entry per access, taken mid-cycle on its first strobe cycle.
  logic        log_rd   [256];
  logic [2:0]  log_addr [256];
  logic [15:0] log_data [256];
  int          log_cyc  [256];
  int          acc_n = 0;
  int          width = 0;
  logic        mon_prev = 1'b0;
  logic [7:0]  rx_log [64];
  int          rx_n = 0;
  int          txr_n = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;

  always @(negedge clk) begin
    if (spi_select && !mon_prev && acc_n < 256) begin
      log_rd[acc_n]   = ~read_n;
      log_addr[acc_n] = mem_addr;
      log_data[acc_n] = read_n ? data_from_cpu : 16'h0000;
      log_cyc[acc_n]  = cyc;
      acc_n++;
      width = 0;
    end
    if (spi_select) width++;
    if (!spi_select && mon_prev && !reset) check("strobe_width", 32'(width), 32'd2);
    mon_prev = spi_select;
    if (rx_valid && rx_n < 64) begin
      rx_log[rx_n] = rx_data;
      rx_n++;
    end
    if (tx_ready) txr_n++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_err = err;
    end
  end

  logic [7:0] tx_bytes [16];

  task automatic exp_acc(input int k, input logic rd, input logic [2:0] a, input logic [15:0] d);
    check($sformatf("acc%0d", k), {12'd0, log_rd[k], log_addr[k], log_data[k]}, {12'd0, rd, a, d});
  endtask

  task automatic exp_setup(input int b);
    exp_acc(b,     1'b0, 3'd2, 16'h0000);
    exp_acc(b + 1, 1'b0, 3'd5, 16'h0001);
    exp_acc(b + 2, 1'b0, 3'd3, 16'h0400);
  endtask

  task automatic send_cmd(input logic [7:0] cb, input logic [4:0] len, input logic rd, output int e0);
    @(negedge clk);
    cmd_byte  = cb;
    cmd_len   = len;
    cmd_rd    = rd;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    cmd_valid = 1'b0;
    check("busy_ready", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_n == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_seen", 32'(done_n - d0), 32'd1);
    check("done_pulse", 32'(done), 32'd0);
    check("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_txn(input logic [7:0] cb, input logic [4:0] len, input logic rd, input int stall,
                         output int b_acc, output int b_rx, output int b_txr, output int e0);
    int d0;
    b_acc = acc_n;
    b_rx  = rx_n;
    b_txr = txr_n;
    d0    = done_n;
    fork
      begin
        if (!rd) begin
          for (int i = 0; i < int'(len); i++) begin
            int n;
            if (i == 1 && stall > 0) begin
              repeat (stall) @(posedge clk);
              #1;
              check("stall_accs", 32'(acc_n - b_acc), 32'd7);
              check("stall_txr", 32'(txr_n - b_txr), 32'd1);
              check("stall_sel", 32'(spi_select), 32'd0);
            end
            tx_data  = tx_bytes[i];
            tx_valid = 1'b1;
            n = 0;
            do begin
              @(posedge clk);
              #1;
              n++;
            end while (!tx_ready && n < 20000);
            check("tx_handshake", 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
          end
        end
      end
      begin
        send_cmd(cb, len, rd, e0);
        wait_done(d0, 30000);
      end
    join
  endtask

  initial begin
    int b, brx, btx, e0, n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {24'd0, cmd_ready, tx_ready, rx_valid, done, err, spi_select, read_n, write_n},
          32'h0000_0083);
    check("rst_bus", {13'd0, mem_addr, data_from_cpu}, 32'd0);
    check("rst_bytes", {16'd0, stat_byte, rx_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ready_post_rst", 32'(cmd_ready), 32'd1);

    // Write: command 8A plus two stream bytes.
    tx_bytes[0] = 8'h11;
    tx_bytes[1] = 8'h22;
    rx_vals[rd_cnt] = 8'h5A;
    rx_vals[rd_cnt + 1] = 8'h00;
    rx_vals[rd_cnt + 2] = 8'h00;
    run_txn(8'h8A, 5'd2, 1'b0, 0, b, brx, btx, e0);
    check("wr_count", 32'(acc_n - b), 32'd10);
    exp_setup(b);
    exp_acc(b + 3, 1'b0, 3'd1, 16'h008A);
    exp_acc(b + 4, 1'b1, 3'd0, 16'h0000);
    exp_acc(b + 5, 1'b0, 3'd1, 16'h0011);
    exp_acc(b + 6, 1'b1, 3'd0, 16'h0000);
    exp_acc(b + 7, 1'b0, 3'd1, 16'h0022);
    exp_acc(b + 8, 1'b1, 3'd0, 16'h0000);
    exp_acc(b + 9, 1'b0, 3'd3, 16'h0000);
    check("wr_no_rx", 32'(rx_n - brx), 32'd0);
    check("wr_txready", 32'(txr_n - btx), 32'd2);
    check("wr_stat", 32'(stat_byte), 32'h5A);
    check("wr_err", 32'(done_err), 32'd0);
    check("lat_first_wr", 32'(log_cyc[b + 3] - e0), 32'd10);
    check("lat_done", 32'(done_cyc - (log_cyc[b + 8] + 2)), 32'd4);

    // Read: command 90, three fill bytes, slave returns A5 01 02 03.
    rx_vals[rd_cnt]     = 8'hA5;
    rx_vals[rd_cnt + 1] = 8'h01;
    rx_vals[rd_cnt + 2] = 8'h02;
    rx_vals[rd_cnt + 3] = 8'h03;
    run_txn(8'h90, 5'd3, 1'b1, 0, b, brx, btx, e0);
    check("rd_count", 32'(acc_n - b), 32'd12);
    exp_setup(b);
    for (int k = 0; k < 4; k++) begin
      exp_acc(b + 3 + 2 * k, 1'b0, 3'd1, (k == 0) ? 16'h0090 : 16'h0000);
      exp_acc(b + 4 + 2 * k, 1'b1, 3'd0, 16'h0000);
    end
    exp_acc(b + 11, 1'b0, 3'd3, 16'h0000);
    check("rd_rx_n", 32'(rx_n - brx), 32'd3);
    check("rd_rx0", 32'(rx_log[brx]),     32'h01);
    check("rd_rx1", 32'(rx_log[brx + 1]), 32'h02);
    check("rd_rx2", 32'(rx_log[brx + 2]), 32'h03);
    check("rd_stat", 32'(stat_byte), 32'hA5);
    check("rd_txready", 32'(txr_n - btx), 32'd0);

    // Zero-length: command byte only.
    rx_vals[rd_cnt] = 8'h3C;
    run_txn(8'h8A, 5'd0, 1'b0, 0, b, brx, btx, e0);
    check("len0_count", 32'(acc_n - b), 32'd6);
    exp_setup(b);
    exp_acc(b + 3, 1'b0, 3'd1, 16'h008A);
    exp_acc(b + 4, 1'b1, 3'd0, 16'h0000);
    exp_acc(b + 5, 1'b0, 3'd3, 16'h0000);
    check("len0_stat", 32'(stat_byte), 32'h3C);
    check("len0_no_rx", 32'(rx_n - brx), 32'd0);
    check("len0_err", 32'(done_err), 32'd0);

    // Write with the second stream byte withheld for 1000 cycles.
    tx_bytes[0] = 8'h33;
    tx_bytes[1] = 8'h44;
    rx_vals[rd_cnt] = 8'h77;
    rx_vals[rd_cnt + 1] = 8'h00;
    rx_vals[rd_cnt + 2] = 8'h00;
    run_txn(8'h8B, 5'd2, 1'b0, 1000, b, brx, btx, e0);
    check("stall_count", 32'(acc_n - b), 32'd10);
    exp_acc(b + 3, 1'b0, 3'd1, 16'h008B);
    exp_acc(b + 5, 1'b0, 3'd1, 16'h0033);
    exp_acc(b + 7, 1'b0, 3'd1, 16'h0044);
    exp_acc(b + 9, 1'b0, 3'd3, 16'h0000);
    check("stall_txready", 32'(txr_n - btx), 32'd2);
    check("stall_stat", 32'(stat_byte), 32'h77);

    // Reset asserted during the first byte write of a read command.
    b = acc_n;
    send_cmd(8'hC3, 5'd3, 1'b1, e0);
    n = 0;
    while (acc_n - b < 4 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_mid_reached", 32'(acc_n - b >= 4), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_flags", {24'd0, cmd_ready, tx_ready, rx_valid, done, err, spi_select, read_n, write_n},
          32'h0000_0083);
    check("midrst_bus", {13'd0, mem_addr, data_from_cpu}, 32'd0);
    check("midrst_bytes", {16'd0, stat_byte, rx_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rx_vals[rd_cnt] = 8'h5C;
    run_txn(8'h8A, 5'd0, 1'b0, 0, b, brx, btx, e0);
    check("post_rst_count", 32'(acc_n - b), 32'd6);
    exp_setup(b);
    exp_acc(b + 3, 1'b0, 3'd1, 16'h008A);
    exp_acc(b + 5, 1'b0, 3'd3, 16'h0000);
    check("post_rst_stat", 32'(stat_byte), 32'h5C);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog: RRDY never rises after the command byte.
    dataavailable = 1'b0;
    run_txn(8'h8A, 5'd0, 1'b0, 0, b, brx, btx, e0);
    check("to_count", 32'(acc_n - b), 32'd5);
    exp_acc(b + 3, 1'b0, 3'd1, 16'h008A);
    exp_acc(b + 4, 1'b0, 3'd3, 16'h0000);
    check("to_wait", 32'(log_cyc[b + 4] - log_cyc[b + 3]), 32'd8195);
    check("to_err", 32'(done_err), 32'd1);
    dataavailable = 1'b1;
    rx_vals[rd_cnt] = 8'h21;
    run_txn(8'h8A, 5'd0, 1'b0, 0, b, brx, btx, e0);
    check("to_err_clear", 32'(done_err), 32'd0);
    check("to_recover_stat", 32'(stat_byte), 32'h21);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
